l1_bus_ctrl: RTL and testbench
==============================

# l1_bus_ctrl

Bus-side responder for the L1 cache request channel. It accepts the L1's level requests (`read_line_req`, `read_req`, `write_through_req`) and turns them into transfers on the CPU-side memory bus:

- a 256-beat line fill, streamed into the L1 data array, or
- one single uncached read or write-through transfer.

It reports completion on `trans_rdy` and failure on `bus_error`. It sits between the L1 and the BIU memory-bus arbiter.

## Interface
Parameters:
- `LINE_BYTES`, 2048: bytes per L1 line.
- `BEAT_BYTES`, 8: bytes per bus beat. A fill is LINE_BYTES/BEAT_BYTES = 256 beats.
- `TIMEOUT_CYCLES`, 255: per-beat no-response limit. Used only when L1_BUS_TIMEOUT_EN is defined.

Ports (reset rst, synchronous, active-high; clock clk):
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `read_line_req`  in  1  L1 requests a line fill (level)
- `read_req`  in  1  L1 requests a single uncached read (level)
- `write_through_req`  in  1  L1 requests a single write (level)
- `L1_size`  in  4  one-hot access size: 0001=1B, 0010=2B, 0100=4B, 1000=8B
- `pa`  in  64  physical address
- `wt_data`  in  64  write-through data
- `line_data`  out  64  fill beat data or single-read data
- `addr_count`  out  11  byte offset of `line_data` within the line
- `line_write`  out  1  write `line_data` at `addr_count` into the L1
- `cache_entry_write`  out  1  commit the tag of the filled line
- `trans_rdy`  out  1  one-cycle completion pulse
- `bus_error`  out  1  one-cycle failure pulse
- `bus_req`  out  1  bus transfer valid
- `bus_we`  out  1  1 = write
- `bus_addr`  out  64  transfer address
- `bus_size`  out  4  one-hot size
- `bus_wdata`  out  64  write data
- `bus_rdata`  in  64  read data, valid with `bus_ack`
- `bus_ack`  in  1  transfer complete
- `bus_err`  in  1  transfer failed

## Operation
States: IDLE, LINE, RD, WR, DONE, ERR.

IDLE
- Accepts a request with priority LINE > RD > WR.
- Latches `pa`, `L1_size` and `wt_data`.

LINE
- `bus_addr` = {`pa`[63:11], 11'b0} + beat×8.
- `bus_size` = 1000; `bus_we` = 0.
- On each `bus_ack`, the next cycle: `line_data` = registered `bus_rdata`, `addr_count` = beat×8, `line_write` = 1.
- The beat counter increments on `bus_ack`. If the slave acks every cycle, `bus_req` stays high with a new address each cycle.
- After the ack of beat 255 → DONE.

RD
- One read at `pa` with the latched size.
- On `bus_ack`, `bus_rdata` is registered into `line_data` → DONE.
- `line_write` stays 0.

WR
- One write at `pa` with `wt_data` and the latched size.
- On `bus_ack` → DONE.

DONE
- `trans_rdy` = 1 for one cycle.
- If the transfer was a fill, `cache_entry_write` = 1 in the same cycle. The final `line_write` (beat 255) also lands in this cycle.
- `line_data` holds the single-read value during this cycle.
- → IDLE.

ERR
- Entered on `bus_err` sampled with `bus_req` high, in any active state. `bus_err` has priority over `bus_ack`.
- `bus_error` = 1 for one cycle; `cache_entry_write` = 0. Beats already written stay in the array but are never tagged valid.
- → IDLE.

Boundaries
- The L1 leaves its request state on the same edge that ends DONE/ERR. IDLE therefore ignores requests for that one cycle; no double-issue.
- A request that deasserts mid-transfer is ignored: the transfer completes.
- `addr_count` wraps from 0x7F8 only on a new fill, never within one.
- Reset mid-transfer: IDLE, all outputs 0 on the next edge. A beat outstanding at the slave is abandoned.

## Timing
- All outputs are registered.
- Reset value of every output is 0, including `line_data`, `addr_count` and `bus_addr`.
- Request → `bus_req`: 1 cycle.
- Zero-wait fill: request at cycle 0; `bus_req` at cycles 1–256; `line_write` at cycles 2–257; DONE at cycle 257.
- Single access, zero-wait: `bus_req` at cycle 1, `trans_rdy` at cycle 2.
- Slave protocol: `bus_addr`, `bus_we`, `bus_size` and `bus_wdata` are stable while `bus_req` is high and no ack/err has been seen.

## Configuration
`L1_BUS_TIMEOUT_EN`
- Defined: a per-beat counter clears on each `bus_req` rise and on every ack. If it reaches TIMEOUT_CYCLES with no ack/err, the block enters ERR exactly as if `bus_err` had been seen.
- Undefined: there is no counter, and the block waits indefinitely.

## Structure
- Package `l1_bus_pkg`: state enum; LINE_BYTES, BEAT_BYTES, BEATS; one-hot size constants SZ_B/SZ_H/SZ_W/SZ_D.
- Sub-module `l1_bus_watchdog`: the timeout counter, instantiated only under L1_BUS_TIMEOUT_EN.

## Test plan
- **Fill, zero-wait.** `read_line_req` with `pa`=0x8000_1234, slave returns data = address.
  Required: 256 beats at 0x8000_1000..0x8000_17F8; `line_write` with `addr_count` 0..0x7F8; `trans_rdy` and `cache_entry_write` together, once, at cycle 257.
- **Single read, 3-cycle wait.** `read_req` with `pa`=0x40, `L1_size`=0100, `bus_rdata`=0xDEAD_BEEF.
  Required: `bus_size`=0100; `trans_rdy` pulse with `line_data`=0xDEAD_BEEF; `line_write`=0.
- **Write-through.** `write_through_req`, `wt_data`=0x1122_3344_5566_7788, `L1_size`=1000.
  Required: `bus_we`=1 with that data; `trans_rdy` one pulse.
- **Error mid-fill.** `bus_err` on beat 17.
  Required: exactly 17 `line_write` pulses; one `bus_error` pulse; no `cache_entry_write` or `trans_rdy`; IDLE after.
- **Timeout (macro defined).** Slave never acks.
  Required: `bus_error` at TIMEOUT_CYCLES+2 cycles after the request.
- **Reset mid-fill, then a new fill.** `rst` at beat 100, then a new fill request.
  Required: all outputs 0 after the reset; the new fill restarts at beat 0.

Source files
------------

// File: rtl/l1_bus_pkg.sv
// ============================================================================
// Module   : l1_bus_pkg
// Brief    : Shared types and constants for the L1 bus-side request responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package l1_bus_pkg;

    localparam int LINE_BYTES = 2048;
    localparam int BEAT_BYTES = 8;
    localparam int BEATS      = LINE_BYTES / BEAT_BYTES;

    localparam logic [3:0] SZ_B = 4'b0001;
    localparam logic [3:0] SZ_H = 4'b0010;
    localparam logic [3:0] SZ_W = 4'b0100;
    localparam logic [3:0] SZ_D = 4'b1000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LINE = 3'd1,
        ST_RD   = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_e;

endpackage

`default_nettype wire

// File: rtl/l1_bus_watchdog.sv
// ============================================================================
// Module   : l1_bus_watchdog
// Brief    : Per-beat no-response counter; flags a beat that waits too long.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module l1_bus_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic req_i,
    input  logic resp_i,
    output logic timeout_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Idle or any response restarts the count, so each beat gets the full budget.
    always_comb begin
        cnt_d = cnt_q;
        if (!req_i || resp_i) begin
            cnt_d = '0;
        end else if (cnt_q != CW'(TIMEOUT_CYCLES)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_o = req_i && !resp_i && (cnt_q == CW'(TIMEOUT_CYCLES));

endmodule

`default_nettype wire

// File: rtl/l1_bus_ctrl.sv
// ============================================================================
// Module   : l1_bus_ctrl
// Brief    : Turns L1 line-fill / uncached-read / write-through requests into
//            memory-bus transfers. Optional per-beat timeout: L1_BUS_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module l1_bus_ctrl #(
    parameter int LINE_BYTES     = 2048,
    parameter int BEAT_BYTES     = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read_line_req,
    input  logic        read_req,
    input  logic        write_through_req,
    input  logic [3:0]  L1_size,
    input  logic [63:0] pa,
    input  logic [63:0] wt_data,
    output logic [63:0] line_data,
    output logic [10:0] addr_count,
    output logic        line_write,
    output logic        cache_entry_write,
    output logic        trans_rdy,
    output logic        bus_error,
    output logic        bus_req,
    output logic        bus_we,
    output logic [63:0] bus_addr,
    output logic [3:0]  bus_size,
    output logic [63:0] bus_wdata,
    input  logic [63:0] bus_rdata,
    input  logic        bus_ack,
    input  logic        bus_err
);

    import l1_bus_pkg::*;

    localparam int NBEATS = LINE_BYTES / BEAT_BYTES;
    localparam int BEAT_W = $clog2(NBEATS);
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int SH     = $clog2(BEAT_BYTES);

    state_e            state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              cool_q, cool_d;
    logic [63:0]       line_data_q, line_data_d;
    logic [10:0]       addr_count_q, addr_count_d;
    logic              line_write_q, line_write_d;
    logic              cew_q, cew_d;
    logic              trans_rdy_q, trans_rdy_d;
    logic              bus_error_q, bus_error_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [63:0]       bus_addr_q, bus_addr_d;
    logic [3:0]        bus_size_q, bus_size_d;
    logic [63:0]       bus_wdata_q, bus_wdata_d;

    logic              w_timeout;
    logic              w_fail;
    logic [BEAT_W-1:0] w_beat_nxt;
    logic [OFF_W-1:0]  w_off;
    logic [OFF_W-1:0]  w_off_nxt;

`ifdef L1_BUS_TIMEOUT_EN
    l1_bus_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .req_i     (bus_req_q),
        .resp_i    (bus_ack | bus_err),
        .timeout_o (w_timeout)
    );
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
    assign w_timeout        = 1'b0;
`endif

    assign w_fail     = bus_req_q && (bus_err || w_timeout);
    assign w_beat_nxt = beat_q + BEAT_W'(1);
    assign w_off      = {beat_q, {SH{1'b0}}};
    assign w_off_nxt  = {w_beat_nxt, {SH{1'b0}}};

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        cool_d       = 1'b0;
        line_data_d  = line_data_q;
        addr_count_d = addr_count_q;
        line_write_d = 1'b0;
        cew_d        = 1'b0;
        trans_rdy_d  = 1'b0;
        bus_error_d  = 1'b0;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_size_d   = bus_size_q;
        bus_wdata_d  = bus_wdata_q;

        case (state_q)
            ST_IDLE: begin
                // The L1 is still dropping its request on the cycle after a
                // completion; cool_q keeps that stale level from re-issuing.
                if (!cool_q && (read_line_req || read_req || write_through_req)) begin
                    bus_req_d   = 1'b1;
                    bus_wdata_d = wt_data;
                    beat_d      = '0;
                    if (read_line_req) begin
                        state_d    = ST_LINE;
                        bus_we_d   = 1'b0;
                        bus_size_d = SZ_D;
                        bus_addr_d = {pa[63:OFF_W], {OFF_W{1'b0}}};
                    end else if (read_req) begin
                        state_d    = ST_RD;
                        bus_we_d   = 1'b0;
                        bus_size_d = L1_size;
                        bus_addr_d = pa;
                    end else begin
                        state_d    = ST_WR;
                        bus_we_d   = 1'b1;
                        bus_size_d = L1_size;
                        bus_addr_d = pa;
                    end
                end
            end

            ST_LINE: begin
                if (w_fail) begin
                    state_d     = ST_ERR;
                    bus_req_d   = 1'b0;
                    bus_error_d = 1'b1;
                end else if (bus_ack) begin
                    line_write_d = 1'b1;
                    line_data_d  = bus_rdata;
                    addr_count_d = 11'(w_off);
                    if (beat_q == BEAT_W'(NBEATS - 1)) begin
                        state_d     = ST_DONE;
                        bus_req_d   = 1'b0;
                        trans_rdy_d = 1'b1;
                        cew_d       = 1'b1;
                    end else begin
                        beat_d     = w_beat_nxt;
                        bus_addr_d = {bus_addr_q[63:OFF_W], w_off_nxt};
                    end
                end
            end

            ST_RD, ST_WR: begin
                if (w_fail) begin
                    state_d     = ST_ERR;
                    bus_req_d   = 1'b0;
                    bus_error_d = 1'b1;
                end else if (bus_ack) begin
                    state_d     = ST_DONE;
                    bus_req_d   = 1'b0;
                    trans_rdy_d = 1'b1;
                    if (state_q == ST_RD) begin
                        line_data_d = bus_rdata;
                    end
                end
            end

            ST_DONE, ST_ERR: begin
                state_d = ST_IDLE;
                cool_d  = 1'b1;
            end

            default: begin
                state_d   = ST_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            beat_q       <= '0;
            cool_q       <= 1'b0;
            line_data_q  <= '0;
            addr_count_q <= '0;
            line_write_q <= 1'b0;
            cew_q        <= 1'b0;
            trans_rdy_q  <= 1'b0;
            bus_error_q  <= 1'b0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_size_q   <= '0;
            bus_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            cool_q       <= cool_d;
            line_data_q  <= line_data_d;
            addr_count_q <= addr_count_d;
            line_write_q <= line_write_d;
            cew_q        <= cew_d;
            trans_rdy_q  <= trans_rdy_d;
            bus_error_q  <= bus_error_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_size_q   <= bus_size_d;
            bus_wdata_q  <= bus_wdata_d;
        end
    end

    assign line_data         = line_data_q;
    assign addr_count        = addr_count_q;
    assign line_write        = line_write_q;
    assign cache_entry_write = cew_q;
    assign trans_rdy         = trans_rdy_q;
    assign bus_error         = bus_error_q;
    assign bus_req           = bus_req_q;
    assign bus_we            = bus_we_q;
    assign bus_addr          = bus_addr_q;
    assign bus_size          = bus_size_q;
    assign bus_wdata         = bus_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_l1_bus_ctrl.sv
// ============================================================================
// Module   : tb_l1_bus_ctrl
// Brief    : Scoreboard bench for l1_bus_ctrl with a configurable bus slave.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_l1_bus_ctrl;

    localparam int TO = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        read_line_req = 1'b0, read_req = 1'b0, write_through_req = 1'b0;
    logic [3:0]  L1_size = '0;
    logic [63:0] pa = '0, wt_data = '0;
    logic [63:0] line_data;
    logic [10:0] addr_count;
    logic        line_write, cache_entry_write, trans_rdy, bus_error;
    logic        bus_req, bus_we;
    logic [63:0] bus_addr, bus_wdata;
    logic [3:0]  bus_size;
    logic [63:0] bus_rdata = '0;
    logic        bus_ack = 1'b0, bus_err = 1'b0;

    always #5 clk = ~clk;

    l1_bus_ctrl #(
        .LINE_BYTES     (2048),
        .BEAT_BYTES     (8),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .read_line_req     (read_line_req),
        .read_req          (read_req),
        .write_through_req (write_through_req),
        .L1_size           (L1_size),
        .pa                (pa),
        .wt_data           (wt_data),
        .line_data         (line_data),
        .addr_count        (addr_count),
        .line_write        (line_write),
        .cache_entry_write (cache_entry_write),
        .trans_rdy         (trans_rdy),
        .bus_error         (bus_error),
        .bus_req           (bus_req),
        .bus_we            (bus_we),
        .bus_addr          (bus_addr),
        .bus_size          (bus_size),
        .bus_wdata         (bus_wdata),
        .bus_rdata         (bus_rdata),
        .bus_ack           (bus_ack),
        .bus_err           (bus_err)
    );

    typedef struct { logic [63:0] addr; logic [3:0] size; logic we; logic [63:0] wd; logic chk_wd; } bus_t;
    typedef struct { logic [10:0] ac; logic [63:0] data; } lw_t;
    typedef struct { logic cew; logic [63:0] data; logic chk_data; int cyc; } dn_t;

    bus_t bus_q[$];
    lw_t  lw_q[$];
    dn_t  dn_q[$];
    int   err_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit sb_off = 1'b0;

    int          s_wait = 0, s_err_beat = -1, s_beats = 0, s_wcnt = 0;
    bit          s_never = 1'b0, s_echo = 1'b1;
    logic [63:0] s_rdata = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_line_data"}, line_data, 64'd0);
        chk({tag, "_addr_count"}, {53'd0, addr_count}, 64'd0);
        chk({tag, "_line_write"}, {63'd0, line_write}, 64'd0);
        chk({tag, "_cew"}, {63'd0, cache_entry_write}, 64'd0);
        chk({tag, "_trans_rdy"}, {63'd0, trans_rdy}, 64'd0);
        chk({tag, "_bus_error"}, {63'd0, bus_error}, 64'd0);
        chk({tag, "_bus_req"}, {63'd0, bus_req}, 64'd0);
        chk({tag, "_bus_we"}, {63'd0, bus_we}, 64'd0);
        chk({tag, "_bus_addr"}, bus_addr, 64'd0);
        chk({tag, "_bus_size"}, {60'd0, bus_size}, 64'd0);
        chk({tag, "_bus_wdata"}, bus_wdata, 64'd0);
    endtask

    // Bus slave: responds after s_wait idle cycles per beat.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            bus_ack = 1'b0;
            bus_err = 1'b0;
            if (bus_req && !rst) begin
                if (!s_never) begin
                    if (s_wcnt < s_wait) begin
                        s_wcnt++;
                    end else begin
                        s_wcnt = 0;
                        if (s_beats == s_err_beat) begin
                            bus_err = 1'b1;
                        end else begin
                            bus_ack   = 1'b1;
                            bus_rdata = s_echo ? bus_addr : s_rdata;
                        end
                        s_beats++;
                    end
                end
            end else begin
                s_wcnt  = 0;
                s_beats = 0;
            end
        end
    end

    bus_t mb;
    lw_t  ml;
    dn_t  md;
    int   me;

    // Monitor: pops expected responses whenever the DUT presents an output.
    initial begin
        forever begin
            @(negedge clk);
            if (!sb_off && !rst) begin
                if (bus_req && (bus_ack || bus_err)) begin
                    if (bus_q.size() == 0) begin
                        chk("bus_extra", {63'd0, bus_req}, 64'd0);
                    end else begin
                        mb = bus_q.pop_front();
                        chk("bus_addr", bus_addr, mb.addr);
                        chk("bus_size", {60'd0, bus_size}, {60'd0, mb.size});
                        chk("bus_we", {63'd0, bus_we}, {63'd0, mb.we});
                        if (mb.chk_wd) chk("bus_wdata", bus_wdata, mb.wd);
                    end
                end
                if (line_write) begin
                    if (lw_q.size() == 0) begin
                        chk("lw_extra", {63'd0, line_write}, 64'd0);
                    end else begin
                        ml = lw_q.pop_front();
                        chk("lw_addr_count", {53'd0, addr_count}, {53'd0, ml.ac});
                        chk("lw_data", line_data, ml.data);
                    end
                end
                if (trans_rdy) begin
                    if (dn_q.size() == 0) begin
                        chk("rdy_extra", {63'd0, trans_rdy}, 64'd0);
                    end else begin
                        md = dn_q.pop_front();
                        chk("rdy_cew", {63'd0, cache_entry_write}, {63'd0, md.cew});
                        if (md.chk_data) chk("rdy_data", line_data, md.data);
                        if (md.cyc >= 0) chk("rdy_cycle", 64'(cyc), 64'(md.cyc));
                    end
                end else if (cache_entry_write) begin
                    chk("cew_stray", {63'd0, cache_entry_write}, 64'd0);
                end
                if (bus_error) begin
                    if (err_q.size() == 0) begin
                        chk("err_extra", {63'd0, bus_error}, 64'd0);
                    end else begin
                        me = err_q.pop_front();
                        chk("err_cycle", 64'(cyc), 64'(me));
                        chk("err_cew", {63'd0, cache_entry_write}, 64'd0);
                    end
                end
            end
        end
    end

    task automatic issue(input int kind, input logic [63:0] pa_v, input logic [3:0] sz,
                         input logic [63:0] wd, output int c);
        @(posedge clk);
        #1;
        pa                = pa_v;
        L1_size           = sz;
        wt_data           = wd;
        read_line_req     = (kind == 0);
        read_req          = (kind == 1);
        write_through_req = (kind == 2);
        c                 = cyc;
    endtask

    task automatic push_fill(input logic [63:0] base, input int nbus, input int nlw);
        for (int i = 0; i < nbus; i++)
            bus_q.push_back('{addr: base + 64'(i * 8), size: 4'b1000, we: 1'b0, wd: 64'd0, chk_wd: 1'b0});
        for (int i = 0; i < nlw; i++)
            lw_q.push_back('{ac: 11'(i * 8), data: base + 64'(i * 8)});
    endtask

    task automatic finish_req(input int limit);
        int   n;
        logic got;
        n   = 0;
        got = 1'b0;
        while (!got && n < limit) begin
            @(negedge clk);
            got = trans_rdy || bus_error;
            n++;
        end
        if (!got) chk("end_seen", {63'd0, got}, 64'd1);
        @(posedge clk);
        #1;
        read_line_req     = 1'b0;
        read_req          = 1'b0;
        write_through_req = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        int c;
        int n;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_zero("reset");

        // Zero-wait line fill; slave returns the beat address as data.
        s_echo = 1'b1; s_wait = 0;
        issue(0, 64'h0000_0000_8000_1234, 4'b1000, 64'd0, c);
        push_fill(64'h0000_0000_8000_1000, 256, 256);
        dn_q.push_back('{cew: 1'b1, data: 64'd0, chk_data: 1'b0, cyc: c + 257});
        finish_req(400);

        // Uncached read with three wait cycles.
        s_echo = 1'b0; s_wait = 3; s_rdata = 64'h0000_0000_DEAD_BEEF;
        issue(1, 64'h40, 4'b0100, 64'd0, c);
        bus_q.push_back('{addr: 64'h40, size: 4'b0100, we: 1'b0, wd: 64'd0, chk_wd: 1'b0});
        dn_q.push_back('{cew: 1'b0, data: 64'h0000_0000_DEAD_BEEF, chk_data: 1'b1, cyc: -1});
        finish_req(50);

        // Zero-wait byte read: completion two cycles after the request.
        s_wait = 0; s_rdata = 64'h0000_0000_0000_00A5;
        issue(1, 64'h1238, 4'b0001, 64'd0, c);
        bus_q.push_back('{addr: 64'h1238, size: 4'b0001, we: 1'b0, wd: 64'd0, chk_wd: 1'b0});
        dn_q.push_back('{cew: 1'b0, data: 64'h0000_0000_0000_00A5, chk_data: 1'b1, cyc: c + 2});
        finish_req(50);

        // Write-through.
        issue(2, 64'h2000, 4'b1000, 64'h1122_3344_5566_7788, c);
        bus_q.push_back('{addr: 64'h2000, size: 4'b1000, we: 1'b1, wd: 64'h1122_3344_5566_7788, chk_wd: 1'b1});
        dn_q.push_back('{cew: 1'b0, data: 64'd0, chk_data: 1'b0, cyc: c + 2});
        finish_req(50);

        // Error on beat 17 of a fill.
        s_echo = 1'b1; s_err_beat = 17;
        issue(0, 64'h0000_0000_1000_0800, 4'b1000, 64'd0, c);
        push_fill(64'h0000_0000_1000_0800, 18, 17);
        err_q.push_back(c + 19);
        finish_req(100);
        s_err_beat = -1;
        chk("idle_after_err", {63'd0, bus_req}, 64'd0);

`ifdef L1_BUS_TIMEOUT_EN
        s_never = 1'b1;
        issue(1, 64'h80, 4'b1000, 64'd0, c);
        err_q.push_back(c + TO + 2);
        finish_req(TO + 20);
        s_never = 1'b0;
`endif

        // Reset at beat 100 of a fill, then a fresh fill from beat 0.
        sb_off = 1'b1;
        issue(0, 64'h0000_0000_5000_0000, 4'b1000, 64'd0, c);
        n = 0;
        while (s_beats < 100 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("beats_before_rst", 64'(s_beats >= 100), 64'd1);
        @(posedge clk);
        #1;
        rst           = 1'b1;
        read_line_req = 1'b0;
        @(posedge clk);
        #1;
        chk_zero("midrst");
        rst    = 1'b0;
        sb_off = 1'b0;
        repeat (2) @(posedge clk);
        issue(0, 64'h0000_0000_3000_0800, 4'b1000, 64'd0, c);
        push_fill(64'h0000_0000_3000_0800, 256, 256);
        dn_q.push_back('{cew: 1'b1, data: 64'd0, chk_data: 1'b0, cyc: c + 257});
        finish_req(400);

        chk("bus_q_left", 64'(bus_q.size()), 64'd0);
        chk("lw_q_left", 64'(lw_q.size()), 64'd0);
        chk("dn_q_left", 64'(dn_q.size()), 64'd0);
        chk("err_q_left", 64'(err_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "bench time limit");
    end

endmodule

`default_nettype wire
